// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Collects N_SAMPLES results from the 2-bit adder ({carry-out, sum}) over a
//   valid/ready handshake and adds them into an ACC_W-bit accumulator. A
//   start/busy/done FSM runs the sequence, and a sticky flag records any
//   carry out of the accumulator width.
//
//   Optional feature: define ACC_SATURATE_EN to make acc clamp at
//   2^ACC_W-1 on overflow. Without it, acc wraps modulo 2^ACC_W.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   begin a run (sampled only in IDLE)
//   in_valid  in   in_co/in_s carry a valid adder result
//   in_co     in   adder carry-out (operand bit 2)
//   in_s      in   adder sum (operand bits 1:0)
//   in_ready  out  result accepted this cycle when in_valid is high
//   acc       out  accumulated value
//   count     out  results accepted in the current run
//   busy      out  run in progress
//   done      out  one-cycle pulse when a run completes
//   ovf       out  sticky overflow flag for the current run
module adder_sum_accumulator #(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_co,
  input  logic [1:0]       in_s,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt;
  logic             in_ready_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             xfer;
  logic             last;
  logic [SUM_W-1:0] sum;

  // in_ready is a flop, so the handshake never sees a comb path from inputs.
  assign xfer = in_valid & in_ready;
  assign last = (count == LAST_CNT);
  assign sum  = {1'b0, acc} + SUM_W'({in_co, in_s});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (xfer && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          count_nxt = count + CNT_W'(1);
          ovf_nxt   = ovf | sum[ACC_W];
`ifdef ACC_SATURATE_EN
          acc_nxt   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_nxt   = sum[ACC_W-1:0];
`endif
        end
      end
      default: ;
    endcase
    // Status flags are registered copies of the upcoming state.
    in_ready_nxt = (state_nxt == S_ACCUM);
    busy_nxt     = (state_nxt == S_ACCUM);
    done_nxt     = (state_nxt == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      count    <= count_nxt;
      ovf      <= ovf_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule
